// File: rtl/bj_redirect_pkg.sv
// Shared types and widths for the execute-stage branch/jump redirect unit.
package bj_redirect_pkg;

  typedef enum logic [3:0] {
    BJ_NONE,
    BJ_JAL,
    BJ_JALR,
    BJ_BEQ,
    BJ_BNE,
    BJ_BLT,
    BJ_BGE,
    BJ_BLTU,
    BJ_BGEU
  } bj_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_SHADOW
  } bj_state_e;

  localparam int unsigned XLEN = 32;

  // The shadow counter is sized for the largest legal depth (7).
  // That way every legal SHADOW_DEPTH shares one counter width.
  localparam int unsigned SHADOW_DEPTH_MAX = 7;
  localparam int unsigned SHADOW_CNT_W     = $clog2(SHADOW_DEPTH_MAX + 1);

  // A target is usable only when it is word aligned.
  function automatic logic is_aligned(input logic [XLEN-1:0] tgt);
    return (tgt[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/bj_redirect_unit_if.sv
// PC-set channel from the execute stage to fetch: one-cycle en pulse plus target.
interface ZionProcessorComponentLib_PcSetChannelItf;

  logic        en;
  logic [31:0] tgtPc;

  modport out    (output en, output tgtPc);
  modport in     (input  en, input  tgtPc);
  modport master (output en, output tgtPc);
  modport slave  (input  en, input  tgtPc);

endinterface

// File: rtl/bj_redirect_unit_cond_eval.sv
// Combinational branch condition, target and alignment evaluation.
module bj_cond_eval
  import bj_redirect_pkg::*;
(
  input  bj_op_e          op_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_c,
  output logic [XLEN-1:0] target_c,
  output logic            aligned_c
);

  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] pc_rel;
  logic [XLEN-1:0] reg_rel;

  // Shared comparators; the carry-out of each add is dropped so targets wrap.
  always_comb begin
    eq      = (rs1_i == rs2_i);
    lt_s    = ($signed(rs1_i) < $signed(rs2_i));
    lt_u    = (rs1_i < rs2_i);
    pc_rel  = XLEN'(pc_i + imm_i);
    reg_rel = XLEN'(rs1_i + imm_i) & ~XLEN'(1);
  end

  // Taken decision and target select per opcode.
  always_comb begin
    taken_c  = 1'b0;
    target_c = pc_rel;
    unique case (op_i)
      BJ_JAL:  taken_c = 1'b1;
      BJ_JALR: begin
        taken_c  = 1'b1;
        target_c = reg_rel;
      end
      BJ_BEQ:  taken_c = eq;
      BJ_BNE:  taken_c = ~eq;
      BJ_BLT:  taken_c = lt_s;
      BJ_BGE:  taken_c = ~lt_s;
      BJ_BLTU: taken_c = lt_u;
      BJ_BGEU: taken_c = ~lt_u;
      default: taken_c = 1'b0;
    endcase
  end

  assign aligned_c = is_aligned(target_c);

endmodule

// File: rtl/bj_redirect_unit.sv
// Execute-stage branch/jump resolver.
// It drives a registered one-cycle redirect to fetch, then squashes the wrong-path shadow.
module bj_redirect_unit
  import bj_redirect_pkg::*;
#(
  parameter int unsigned     SHADOW_DEPTH = 2,
  parameter logic [XLEN-1:0] RST_CFG      = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iValid,
  input  logic            iStall,
  input  bj_op_e          iBjOp,
  input  logic [XLEN-1:0] iPc,
  input  logic [XLEN-1:0] iImm,
  input  logic [XLEN-1:0] iRs1,
  input  logic [XLEN-1:0] iRs2,
  ZionProcessorComponentLib_PcSetChannelItf.out oBjBus,
  output logic            oSquash,
  output logic [XLEN-1:0] oLinkData,
  output logic            oMisalign
);

  bj_state_e               state_q, state_d;
  logic [SHADOW_CNT_W-1:0] cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic [XLEN-1:0]         tgt_q, tgt_d;
  logic                    squash_q, squash_d;
  logic                    mis_q, mis_d;

  logic                    resolve;
  logic                    taken;
  logic                    aligned;
  logic [XLEN-1:0]         target;

  bj_cond_eval u_cond_eval (
    .op_i      (iBjOp),
    .pc_i      (iPc),
    .imm_i     (iImm),
    .rs1_i     (iRs1),
    .rs2_i     (iRs2),
    .taken_c   (taken),
    .target_c  (target),
    .aligned_c (aligned)
  );

  // Instructions that arrive in the shadow are wrong-path and never resolve.
  assign resolve = iValid & ~iStall & (state_q == ST_IDLE);

  // Next-state logic: enter the shadow on an aligned taken target.
  // Count the shadow down independent of the stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    tgt_d    = tgt_q;
    squash_d = 1'b0;
    mis_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (resolve && taken) begin
          if (aligned) begin
            state_d  = ST_SHADOW;
            cnt_d    = SHADOW_CNT_W'(SHADOW_DEPTH);
            en_d     = 1'b1;
            tgt_d    = target;
            squash_d = 1'b1;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      ST_SHADOW: begin
        cnt_d = cnt_q - SHADOW_CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = ST_IDLE;
        end else begin
          squash_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, shadow counter and output registers; reset aborts any redirect or shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      tgt_q    <= RST_CFG;
      squash_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      tgt_q    <= tgt_d;
      squash_q <= squash_d;
      mis_q    <= mis_d;
    end
  end

  assign oBjBus.en    = en_q;
  assign oBjBus.tgtPc = tgt_q;
  assign oSquash      = squash_q;
  assign oMisalign    = mis_q;
  assign oLinkData    = XLEN'(iPc + XLEN'(4));

endmodule

// File: tb/tb_bj_redirect_unit.sv
// Directed bench for bj_redirect_unit: vector table plus multi-cycle corner sequences.
module tb_bj_redirect_unit;
  import bj_redirect_pkg::*;

  logic        clk;
  logic        rst;
  logic        iValid;
  logic        iStall;
  bj_op_e      iBjOp;
  logic [31:0] iPc;
  logic [31:0] iImm;
  logic [31:0] iRs1;
  logic [31:0] iRs2;
  logic        oSquash;
  logic [31:0] oLinkData;
  logic        oMisalign;

  int n_checks;
  int n_errors;

  ZionProcessorComponentLib_PcSetChannelItf bj_bus ();

  bj_redirect_unit #(.SHADOW_DEPTH(2), .RST_CFG(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .iValid    (iValid),
    .iStall    (iStall),
    .iBjOp     (iBjOp),
    .iPc       (iPc),
    .iImm      (iImm),
    .iRs1      (iRs1),
    .iRs2      (iRs2),
    .oBjBus    (bj_bus),
    .oSquash   (oSquash),
    .oLinkData (oLinkData),
    .oMisalign (oMisalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bj_op_e      op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        exp_en;
    logic        exp_mis;
    logic [31:0] exp_tgt;
    logic [31:0] exp_link;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bj_op_e op, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    iValid = 1'b1;
    iBjOp  = op;
    iPc    = pc;
    iImm   = imm;
    iRs1   = rs1;
    iRs2   = rs2;
  endtask

  task automatic idle_inputs();
    iValid = 1'b0;
    iStall = 1'b0;
    iBjOp  = BJ_NONE;
    iPc    = '0;
    iImm   = '0;
    iRs1   = '0;
    iRs2   = '0;
  endtask

  int en_seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    idle_inputs();

    // Hand-computed vectors; exp_tgt is the tgtPc held after the vector.
    vecs[0]  = '{BJ_BEQ,  32'h0000_0100, 32'h0000_0020, 32'h5,          32'h5,          1'b1, 1'b0, 32'h0000_0120, 32'h0000_0104};
    vecs[1]  = '{BJ_BLT,  32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF,  32'h1,          1'b1, 1'b0, 32'h0000_0240, 32'h0000_0204};
    vecs[2]  = '{BJ_BLTU, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF,  32'h1,          1'b0, 1'b0, 32'h0000_0240, 32'h0000_0204};
    vecs[3]  = '{BJ_JALR, 32'h0000_0300, 32'h0000_0000, 32'h0000_2003,  32'h0,          1'b0, 1'b1, 32'h0000_0240, 32'h0000_0304};
    vecs[4]  = '{BJ_JALR, 32'h0000_0304, 32'h0000_0000, 32'h0000_2005,  32'h0,          1'b1, 1'b0, 32'h0000_2004, 32'h0000_0308};
    vecs[5]  = '{BJ_JAL,  32'hFFFF_FFFC, 32'h0000_0008, 32'h0,          32'h0,          1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000};
    vecs[6]  = '{BJ_BNE,  32'h0000_0010, 32'h0000_0100, 32'h3,          32'h3,          1'b0, 1'b0, 32'h0000_0004, 32'h0000_0014};
    vecs[7]  = '{BJ_BGE,  32'h0000_0400, 32'hFFFF_FFFC, 32'h1,          32'hFFFF_FFFF,  1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0404};
    vecs[8]  = '{BJ_BGEU, 32'h0000_0400, 32'hFFFF_FFFC, 32'h1,          32'hFFFF_FFFF,  1'b0, 1'b0, 32'h0000_03FC, 32'h0000_0404};
    vecs[9]  = '{BJ_BEQ,  32'h0000_0100, 32'h0000_0002, 32'h7,          32'h7,          1'b0, 1'b1, 32'h0000_03FC, 32'h0000_0104};
    vecs[10] = '{BJ_NONE, 32'h0000_0600, 32'h0000_0010, 32'h0,          32'h0,          1'b0, 1'b0, 32'h0000_03FC, 32'h0000_0604};
    vecs[11] = '{BJ_JAL,  32'h0000_1000, 32'h0000_0800, 32'h0,          32'h0,          1'b1, 1'b0, 32'h0000_1800, 32'h0000_1004};

    // Reset state.
    #12;
    check("rst_en",     32'(bj_bus.en),    32'h0);
    check("rst_tgt",    bj_bus.tgtPc,      32'h0);
    check("rst_squash", 32'(oSquash),      32'h0);
    check("rst_mis",    32'(oMisalign),    32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table: resolve in N, check N+1 outputs, shadow in N+2, IDLE in N+3.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
      #1;
      check($sformatf("v%0d_link", i), oLinkData, vecs[i].exp_link);
      @(negedge clk);
      idle_inputs();
      check($sformatf("v%0d_en", i),     32'(bj_bus.en), 32'(vecs[i].exp_en));
      check($sformatf("v%0d_tgt", i),    bj_bus.tgtPc,   vecs[i].exp_tgt);
      check($sformatf("v%0d_mis", i),    32'(oMisalign), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d_sq1", i),    32'(oSquash),   32'(vecs[i].exp_en));
      @(negedge clk);
      check($sformatf("v%0d_en2", i),    32'(bj_bus.en), 32'h0);
      check($sformatf("v%0d_mis2", i),   32'(oMisalign), 32'h0);
      check($sformatf("v%0d_sq2", i),    32'(oSquash),   32'(vecs[i].exp_en));
      @(negedge clk);
      check($sformatf("v%0d_sq3", i),    32'(oSquash),   32'h0);
      check($sformatf("v%0d_tgt3", i),   bj_bus.tgtPc,   vecs[i].exp_tgt);
    end

    // Back-to-back: JAL then taken BNE; only the JAL redirects.
    @(negedge clk);
    drive(BJ_JAL, 32'h0000_0500, 32'h0000_0100, 32'h0, 32'h0);
    @(negedge clk);
    check("b2b_en1",  32'(bj_bus.en), 32'h1);
    check("b2b_tgt1", bj_bus.tgtPc,   32'h0000_0600);
    drive(BJ_BNE, 32'h0000_0700, 32'h0000_0010, 32'h1, 32'h2);
    @(negedge clk);
    check("b2b_sq",   32'(oSquash),   32'h1);
    idle_inputs();
    en_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bj_bus.en) en_seen++;
      @(negedge clk);
    end
    check("b2b_extra_en", 32'(en_seen),  32'h0);
    check("b2b_tgt_hold", bj_bus.tgtPc,  32'h0000_0600);
    check("b2b_sq_end",   32'(oSquash),  32'h0);

    // Stall: held for 3 cycles, resolves when stall drops; shadow counts under stall.
    @(negedge clk);
    drive(BJ_BEQ, 32'h0000_0800, 32'h0000_0010, 32'h9, 32'h9);
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_en%0d", k), 32'(bj_bus.en), 32'h0);
      check($sformatf("stall_sq%0d", k), 32'(oSquash),   32'h0);
    end
    iStall = 1'b0;
    @(negedge clk);
    check("stall_en_rel", 32'(bj_bus.en), 32'h1);
    check("stall_tgt",    bj_bus.tgtPc,   32'h0000_0810);
    check("stall_sq_a",   32'(oSquash),   32'h1);
    iStall = 1'b1;
    @(negedge clk);
    check("stall_sq_b",   32'(oSquash),   32'h1);
    check("stall_en_b",   32'(bj_bus.en), 32'h0);
    @(negedge clk);
    check("stall_sq_c",   32'(oSquash),   32'h0);
    @(negedge clk);
    check("stall_en_d",   32'(bj_bus.en), 32'h0);
    idle_inputs();
    @(negedge clk);

    // Reset during the shadow aborts at once and leaves no stale redirect.
    drive(BJ_JAL, 32'h0000_0900, 32'h0000_0040, 32'h0, 32'h0);
    @(negedge clk);
    idle_inputs();
    check("rs_en_pre",  32'(bj_bus.en), 32'h1);
    check("rs_tgt_pre", bj_bus.tgtPc,   32'h0000_0940);
    #2;
    rst = 1'b0;
    #1;
    check("rs_en",     32'(bj_bus.en), 32'h0);
    check("rs_sq",     32'(oSquash),   32'h0);
    check("rs_tgt",    bj_bus.tgtPc,   32'h0);
    @(negedge clk);
    rst = 1'b1;
    en_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bj_bus.en || oSquash) en_seen++;
    end
    check("rs_no_stale", 32'(en_seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
